// File: rtl/handshake_pipeline.sv
// Valid/ready register-slice pipeline moving a WIDTH-bit payload through NUM_STAGES stages.
// Build option HANDSHAKE_PIPELINE_SKID_EN: 2-entry skid stages with registered ready.
module handshake_pipeline #(
  parameter int WIDTH      = 8,
  parameter int NUM_STAGES = 8
) (
  input  logic             clk_i,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready
);

  if (NUM_STAGES == 0) begin : g_pass
    assign data_out       = data_in;
    assign data_out_valid = data_in_valid;
    assign data_in_ready  = data_out_ready;
  end else begin : g_pipe
    // Index 0 of each chain is the producer side, index NUM_STAGES the consumer side.
    logic [NUM_STAGES:0]              vld_c;
    logic [NUM_STAGES:0][WIDTH-1:0]   dat_c;
    logic [NUM_STAGES:0]              rdy_c;
    logic [NUM_STAGES-1:0]            valid_q, valid_d;
    logic [NUM_STAGES-1:0][WIDTH-1:0] data_q, data_d;

    assign vld_c          = {valid_q, data_in_valid};
    assign dat_c          = {data_q, data_in};
    assign data_in_ready  = rdy_c[0];
    assign data_out_valid = vld_c[NUM_STAGES];
    assign data_out       = dat_c[NUM_STAGES];

`ifdef HANDSHAKE_PIPELINE_SKID_EN
    logic [NUM_STAGES-1:0]            skid_valid_q, skid_valid_d;
    logic [NUM_STAGES-1:0][WIDTH-1:0] skid_data_q, skid_data_d;

    // Upstream ready depends only on the local skid flop, breaking the ready chain.
    assign rdy_c = {data_out_ready, ~skid_valid_q};

    always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (rdy_c[k+1] || !valid_q[k]) begin
          if (skid_valid_q[k]) begin
            valid_d[k]      = 1'b1;
            data_d[k]       = skid_data_q[k];
            skid_valid_d[k] = 1'b0;
          end else begin
            valid_d[k] = vld_c[k];
            data_d[k]  = dat_c[k];
          end
        end else if (vld_c[k] && rdy_c[k]) begin
          skid_valid_d[k] = 1'b1;
          skid_data_d[k]  = dat_c[k];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (!arst_n) begin
        skid_valid_q <= '0;
        skid_data_q  <= '0;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
      end
    end
`else
    always_comb begin
      rdy_c             = '0;
      rdy_c[NUM_STAGES] = data_out_ready;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        rdy_c[k] = !valid_q[k] || rdy_c[k+1];
      end
    end

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (rdy_c[k]) begin
          valid_d[k] = vld_c[k];
          data_d[k]  = dat_c[k];
        end
      end
    end
`endif

    always_ff @(posedge clk_i) begin
      if (!arst_n) begin
        valid_q <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end
  end

endmodule

// File: tb/tb_handshake_pipeline.sv
// Scoreboard bench for handshake_pipeline: directed vectors plus a random-stall soak.
module tb_handshake_pipeline;
  localparam int NS = 8;
`ifdef HANDSHAKE_PIPELINE_SKID_EN
  localparam int CAP = 2 * NS;
`else
  localparam int CAP = NS;
`endif

  logic       clk_i;
  logic       arst_n;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;

  logic [7:0] exp_q[$];
  int         total, bad, in_cnt, out_cnt;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic [7:0] exp_b;
  int         acc, base, cyc;

  handshake_pipeline #(.WIDTH(8), .NUM_STAGES(NS)) dut (
    .clk_i          (clk_i),
    .arst_n         (arst_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    total = 0; bad = 0; in_cnt = 0; out_cnt = 0;
    prev_stall = 1'b0; prev_data = '0;
    arst_n = 1'b0; data_in = 8'hFF; data_in_valid = 1'b1; data_out_ready = 1'b1;

    // Monitor: transfers are judged at the falling edge, ahead of the rising edge that commits them.
    fork
      forever begin
        @(negedge clk_i);
        if (!arst_n) begin
          exp_q.delete();
          prev_stall = 1'b0;
        end else begin
          if (prev_stall) begin
            chk("stable_valid", data_out_valid, 1);
            chk("stable_data", data_out, prev_data);
          end
          if (data_out_valid && data_out_ready) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL spurious_out: got %0h want none", data_out);
            end else begin
              exp_b = exp_q.pop_front();
              chk("order", data_out, exp_b);
            end
            out_cnt++;
          end
          if (data_in_valid && data_in_ready) begin
            exp_q.push_back(data_in);
            in_cnt++;
          end
          prev_stall = data_out_valid && !data_out_ready;
          prev_data  = data_out;
        end
      end
    join_none

    // Reset with junk on the input
    step(); step();
    chk("rst_valid", data_out_valid, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_in_ready", data_in_ready, 1);
    arst_n = 1'b1; data_in_valid = 1'b0; data_in = 8'h00;
    step();

    // Latency of a single beat
    data_in = 8'hA5; data_in_valid = 1'b1;
    @(negedge clk_i);
    chk("lat_accept", data_in_ready, 1);
    step();
    data_in_valid = 1'b0; data_in = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == NS - 1) begin
        chk("lat_valid", data_out_valid, 1);
        chk("lat_data", data_out, 8'hA5);
      end else begin
        chk("lat_idle", data_out_valid, 0);
      end
    end

    // Back-to-back streaming 0x00..0x1F
    base = out_cnt;
    data_in = 8'h00; data_in_valid = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk_i);
      if (j < 32) chk("stream_in_ready", data_in_ready, 1);
      step();
      if (j >= NS - 1 && j <= 31 + NS - 1) begin
        chk("stream_valid", data_out_valid, 1);
        chk("stream_data", data_out, 32'(j - (NS - 1)));
      end else if (j > 31 + NS - 1) begin
        chk("stream_tail", data_out_valid, 0);
      end
      data_in_valid = (j + 1 < 32);
      data_in       = 8'(j + 1);
    end
    chk("stream_count", out_cnt - base, 32);
    data_in_valid = 1'b0;

    // Backpressure fill and drain
    data_out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 100 && acc < CAP; c++) begin
      data_in = 8'(8'h10 + acc); data_in_valid = 1'b1;
      @(negedge clk_i);
      if (data_in_ready) acc++;
      step();
    end
    chk("bp_accepted", acc, CAP);
    data_in = 8'(8'h10 + CAP);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("bp_full_ready", data_in_ready, 0);
      chk("bp_head_valid", data_out_valid, 1);
      chk("bp_head_data", data_out, 8'h10);
      step();
    end
    data_in_valid = 1'b0;
    base = out_cnt;
    data_out_ready = 1'b1;
    cyc = 0;
    while (out_cnt - base < CAP && cyc < 200) begin step(); cyc++; end
    chk("bp_drained", out_cnt - base, CAP);

    // Random valid/ready soak
    base = in_cnt; cyc = 0;
    while (in_cnt - base < 1000 && cyc < 20000) begin
      data_in_valid  = 1'($urandom_range(0, 1));
      data_out_ready = 1'($urandom_range(0, 1));
      data_in        = 8'($urandom);
      step();
      cyc++;
    end
    chk("rand_sent", in_cnt - base, 1000);
    data_in_valid = 1'b0; data_out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin step(); cyc++; end
    chk("rand_drained", exp_q.size(), 0);
    step();

    // Reset with five beats in flight
    data_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(8'h40 + i); data_in_valid = 1'b1;
      step();
    end
    data_in_valid = 1'b0;
    repeat (12) step();
    chk("mid_pre_valid", data_out_valid, 1);
    chk("mid_pre_data", data_out, 8'h40);
    arst_n = 1'b0;
    step();
    chk("mid_rst_valid", data_out_valid, 0);
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_in_ready", data_in_ready, 1);
    arst_n = 1'b1; data_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("mid_no_stale", data_out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
